// File: rtl/key_debounce_scheduler.sv
// Debounces NUM_KEYS raw buttons on one shared scan tick and serializes presses into a valid/ready event stream.
// Optional macro KEY_SCHED_RELEASE_EVT_EN also reports releases (adds port evt_release).

module key_debounce_lane #(
   parameter int CW         = 3,
   parameter int STABLE_CNT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic key_i,
   input  logic sample_i,
   output logic db_o,
   output logic flip_o
);
   logic          sync1_q, sync2_q, db_q;
   logic [CW-1:0] cnt_q;

   // flip_o is high in the cycle whose edge toggles db_q
   assign flip_o = sample_i && (sync2_q != db_q) && (cnt_q == CW'(STABLE_CNT - 1));
   assign db_o   = db_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         db_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
         if (sample_i) begin
            if (sync2_q == db_q) begin
               cnt_q <= '0;
            end else if (flip_o) begin
               db_q  <= ~db_q;
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end
endmodule

module key_debounce_scheduler #(
   parameter int NUM_KEYS   = 4,
   parameter int TICK_DIV   = 50000,
   parameter int STABLE_CNT = 4,
   parameter int ID_W       = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] keys_in,
   output logic [NUM_KEYS-1:0] keys_db,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [ID_W-1:0]     evt_id,
`ifdef KEY_SCHED_RELEASE_EVT_EN
   output logic                evt_release,
`endif
   output logic                evt_overrun
);
   localparam int TCW = $clog2(TICK_DIV);
   localparam int CW  = $clog2(STABLE_CNT) + 1;
`ifdef KEY_SCHED_RELEASE_EVT_EN
   // source 2i = press of key i, 2i+1 = release of key i (press outranks release)
   localparam int NSRC = 2 * NUM_KEYS;
`else
   localparam int NSRC = NUM_KEYS;
`endif
   localparam int SRC_W = $clog2(NSRC);

   logic [TCW-1:0]      tick_cnt_q, tick_cnt_d;
   logic                tick;
   logic [ID_W-1:0]     scan_ptr_q, scan_ptr_d;
   logic [NUM_KEYS-1:0] sample, flip, db;
   logic [NSRC-1:0]     pend_q, pend_d, set, gnt_mask;
   logic [SRC_W-1:0]    rr_q, rr_d, gnt_src;
   logic [SRC_W:0]      arb_sum;
   logic                gnt_found, free;
   logic                evt_valid_q, evt_valid_d;
   logic [ID_W-1:0]     evt_id_q, evt_id_d;
   logic                overrun_q, overrun_d;
`ifdef KEY_SCHED_RELEASE_EVT_EN
   logic                evt_rel_q, evt_rel_d;
`endif

   always_comb begin
      tick       = (tick_cnt_q == TCW'(TICK_DIV - 1));
      tick_cnt_d = tick ? '0 : tick_cnt_q + TCW'(1);
      scan_ptr_d = scan_ptr_q;
      if (tick)
         scan_ptr_d = (scan_ptr_q == ID_W'(NUM_KEYS - 1)) ? '0 : scan_ptr_q + ID_W'(1);
   end

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
      assign sample[g] = tick && (scan_ptr_q == ID_W'(g));

      key_debounce_lane #(.CW(CW), .STABLE_CNT(STABLE_CNT)) u_lane (
         .clock    (clock),
         .reset    (reset),
         .key_i    (keys_in[g]),
         .sample_i (sample[g]),
         .db_o     (db[g]),
         .flip_o   (flip[g])
      );

`ifdef KEY_SCHED_RELEASE_EVT_EN
      assign set[2*g]   = flip[g] && !db[g];
      assign set[2*g+1] = flip[g] &&  db[g];
`else
      assign set[g] = flip[g] && !db[g];
`endif
   end

   // Round-robin search starting at rr_q, which points just past the last grant
   always_comb begin
      free      = !evt_valid_q || evt_ready;
      gnt_found = 1'b0;
      gnt_src   = '0;
      arb_sum   = '0;
      for (int off = 0; off < NSRC; off++) begin
         arb_sum = {1'b0, rr_q} + (SRC_W+1)'(off);
         if (arb_sum >= (SRC_W+1)'(NSRC))
            arb_sum = arb_sum - (SRC_W+1)'(NSRC);
         if (!gnt_found && pend_q[arb_sum[SRC_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_src   = arb_sum[SRC_W-1:0];
         end
      end

      gnt_mask    = '0;
      rr_d        = rr_q;
      evt_valid_d = evt_valid_q;
      evt_id_d    = evt_id_q;
`ifdef KEY_SCHED_RELEASE_EVT_EN
      evt_rel_d   = evt_rel_q;
`endif
      if (free) begin
         evt_valid_d = gnt_found;
         if (gnt_found) begin
            gnt_mask[gnt_src] = 1'b1;
            rr_d = (gnt_src == SRC_W'(NSRC - 1)) ? '0 : gnt_src + SRC_W'(1);
`ifdef KEY_SCHED_RELEASE_EVT_EN
            evt_id_d  = gnt_src[SRC_W-1:1];
            evt_rel_d = gnt_src[0];
`else
            evt_id_d  = gnt_src;
`endif
         end
      end

      // a set landing on a bit being granted this cycle re-queues it rather than overrunning
      pend_d    = (pend_q & ~gnt_mask) | set;
      overrun_d = overrun_q | (|(set & pend_q & ~gnt_mask));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tick_cnt_q  <= '0;
         scan_ptr_q  <= '0;
         pend_q      <= '0;
         rr_q        <= '0;
         evt_valid_q <= 1'b0;
         evt_id_q    <= '0;
         overrun_q   <= 1'b0;
`ifdef KEY_SCHED_RELEASE_EVT_EN
         evt_rel_q   <= 1'b0;
`endif
      end else begin
         tick_cnt_q  <= tick_cnt_d;
         scan_ptr_q  <= scan_ptr_d;
         pend_q      <= pend_d;
         rr_q        <= rr_d;
         evt_valid_q <= evt_valid_d;
         evt_id_q    <= evt_id_d;
         overrun_q   <= overrun_d;
`ifdef KEY_SCHED_RELEASE_EVT_EN
         evt_rel_q   <= evt_rel_d;
`endif
      end
   end

   assign keys_db     = db;
   assign evt_valid   = evt_valid_q;
   assign evt_id      = evt_id_q;
   assign evt_overrun = overrun_q;
`ifdef KEY_SCHED_RELEASE_EVT_EN
   assign evt_release = evt_rel_q;
`endif
endmodule

// File: tb/tb_key_debounce_scheduler.sv
// Scoreboard bench for key_debounce_scheduler (NUM_KEYS=4, TICK_DIV=4, STABLE_CNT=3).
// Key k is sampled at edges where cyc % 16 == 4*(k+1) % 16, counting edges since reset release.

module tb_key_debounce_scheduler;
   logic       clock     = 1'b0;
   logic       reset     = 1'b1;
   logic [3:0] keys_in   = 4'b1111;
   logic       evt_ready = 1'b0;
   logic [3:0] keys_db;
   logic       evt_valid;
   logic [1:0] evt_id;
   logic       evt_overrun;
   logic       evt_release;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct packed {
      logic [1:0] id;
      logic       rel;
   } evt_t;
   evt_t sb[$];

   key_debounce_scheduler #(
      .NUM_KEYS(4), .TICK_DIV(4), .STABLE_CNT(3), .ID_W(2)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .keys_in     (keys_in),
      .keys_db     (keys_db),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_id      (evt_id),
`ifdef KEY_SCHED_RELEASE_EVT_EN
      .evt_release (evt_release),
`endif
      .evt_overrun (evt_overrun)
   );
`ifndef KEY_SCHED_RELEASE_EVT_EN
   assign evt_release = 1'b0;
`endif

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) step(1);
   endtask

   task automatic align16();
      do step(1); while (cyc % 16 != 0);
   endtask

   task automatic push(input logic [1:0] id, input logic rel);
      evt_t e;
      e.id  = id;
      e.rel = rel;
      sb.push_back(e);
   endtask

   // Pops one expected event per handshake, sampled mid-cycle
   task automatic monitor();
      forever begin
         @(negedge clock);
         if (!reset && evt_valid && evt_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_event: actual id=%0d rel=%0d expected none", evt_id, evt_release);
            end else begin
               evt_t e = sb.pop_front();
               chk("event_id_rel", {29'd0, evt_id, evt_release}, {29'd0, e.id, e.rel});
            end
         end
      end
   endtask

   task automatic wait_db(input int bit_i, output bit found);
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         step(1);
         if (keys_db[bit_i]) found = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit found;
      fork
         monitor();
      join_none

      // 1: reset with all keys held, then first debounce on key 0 at its 3rd sample (edge 36)
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("rst_keys_db", keys_db, 0);
         chk("rst_valid", evt_valid, 0);
         chk("rst_overrun", evt_overrun, 0);
      end
      reset     = 1'b0;
      evt_ready = 1'b1;
      push(0, 0); push(1, 0); push(2, 0); push(3, 0);
      wait_cyc(35);
      chk("t1_db0_before_3rd", keys_db[0], 0);
      step(1);
      chk("t1_db0_at_3rd", keys_db[0], 1);
      wait_cyc(60);
      chk("t1_db_all", keys_db, 4'hF);
      keys_in = 4'b0000;
`ifdef KEY_SCHED_RELEASE_EVT_EN
      push(0, 1); push(1, 1); push(2, 1); push(3, 1);
`endif
      step(64);
      chk("t1_db_released", keys_db, 0);
      chk("t1_sb_empty", sb.size(), 0);

      // 2: single press on key 1, one-cycle event one edge after the level flips
      keys_in = 4'b0010;
      push(1, 0);
      wait_db(1, found);
      chk("t2_db1_rise", found, 1);
      chk("t2_valid_flip_cycle", evt_valid, 0);
      step(1);
      chk("t2_valid", evt_valid, 1);
      chk("t2_id", evt_id, 1);
      step(1);
      chk("t2_valid_drop", evt_valid, 0);
      step(20);
      chk("t2_db", keys_db, 4'b0010);
      keys_in = 4'b0000;
`ifdef KEY_SCHED_RELEASE_EVT_EN
      push(1, 1);
`endif
      step(64);
      chk("t2_db_released", keys_db, 0);

      // 3: 20-cycle glitch on key 2 is filtered
      keys_in = 4'b0100;
      step(20);
      chk("t3_db_glitch", keys_db, 0);
      keys_in = 4'b0000;
      step(48);
      chk("t3_db_after", keys_db, 0);
      chk("t3_valid", evt_valid, 0);

      // 4: keys 0 and 3 together with consumer stalled; key 0 is sampled first after alignment
      evt_ready = 1'b0;
      align16();
      keys_in = 4'b1001;
      push(0, 0); push(3, 0);
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         step(1);
         if (evt_valid) found = 1'b1;
      end
      chk("t4_valid", found, 1);
      chk("t4_first_id", evt_id, 0);
      step(20);
      chk("t4_hold_valid", evt_valid, 1);
      chk("t4_hold_id", evt_id, 0);
      chk("t4_db", keys_db, 4'b1001);
      evt_ready = 1'b1;
      step(1);
      evt_ready = 1'b0;
      chk("t4_second_valid", evt_valid, 1);
      chk("t4_second_id", evt_id, 3);
      step(3);
      chk("t4_second_hold", evt_id, 3);
      evt_ready = 1'b1;
      step(1);
      evt_ready = 1'b0;
      chk("t4_drain", evt_valid, 0);
      align16();
      keys_in   = 4'b0000;
      evt_ready = 1'b1;
`ifdef KEY_SCHED_RELEASE_EVT_EN
      push(0, 1); push(3, 1);
`endif
      step(64);
      chk("t4_db_released", keys_db, 0);

      // 5: three presses on key 1 with consumer stalled -> overrun, then reset discards all
      evt_ready = 1'b0;
      for (int p = 0; p < 3; p++) begin
         keys_in = 4'b0010;
         step(64);
         chk("t5_valid", evt_valid, 1);
         chk("t5_id", evt_id, 1);
         chk("t5_overrun", evt_overrun, (p == 2) ? 1 : 0);
         if (p < 2) begin
            keys_in = 4'b0000;
            step(64);
         end
      end
      reset   = 1'b1;
      keys_in = 4'b0000;
      step(1);
      chk("t5_rst_valid", evt_valid, 0);
      chk("t5_rst_overrun", evt_overrun, 0);
      chk("t5_rst_db", keys_db, 0);
      reset = 1'b0;
      step(2);

`ifdef KEY_SCHED_RELEASE_EVT_EN
      // 6: press then release key 1 produces a press and a release event
      evt_ready = 1'b1;
      keys_in   = 4'b0010;
      push(1, 0);
      step(64);
      keys_in = 4'b0000;
      push(1, 1);
      step(64);
`endif

      chk("final_sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
